// File: rtl/seq_alu_if.sv
// Request/response bundle between the CPU controller and the multi-cycle ALU.
// The controller drives the operation request; the ALU returns results and
// handshake status.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUOp, A, B,
    input  result, hi, zero, overflow, div_zero, busy, done
  );

  modport slave (
    input  start, ALUOp, A, B,
    output result, hi, zero, overflow, div_zero, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with registered outputs and a start/busy/done handshake.
// Single-cycle ops complete in one edge; MULU (shift-add) and DIVU
// (restoring) take one iteration per edge for WIDTH edges.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     CLK,
  input  logic     Reset,
  seq_alu_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t state, state_next;

  // Iteration registers shared by MUL and DIV:
  //   op_b : multiplicand / divisor
  //   acc  : product high half / partial remainder
  //   lo   : multiplier shifting out, product low half shifting in / quotient
  logic [WIDTH-1:0] op_b, acc, lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q, ovf_q, dz_q, busy_q, done_q;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic               last, is_mulu, is_divu, b_is_zero;

  assign is_mulu   = (bus.ALUOp == OP_MULU);
  assign is_divu   = (bus.ALUOp == OP_DIVU);
  assign b_is_zero = (bus.B == '0);
  assign last      = (cnt == CNT_W'(WIDTH - 1));

  // Single-cycle result and signed overflow for the current request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = bus.A + bus.B;
    diff    = bus.A - bus.B;
    case (bus.ALUOp)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL:  alu_res = bus.B << bus.A[SH_W-1:0];
      OP_SRL:  alu_res = bus.B >> bus.A[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // One shift-add and one restoring-divide step from the current iteration state.
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, op_b} : '0);
    mul_next  = {mul_sum, lo[WIDTH-1:1]};
    div_shift = {acc, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b};
    div_ok    = ~div_diff[WIDTH];
    div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo   = {lo[WIDTH-2:0], div_ok};
  end

  // Next-state logic: leave IDLE only for an iterating op, return after WIDTH steps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) begin
        if (is_mulu)                     state_next = MUL;
        else if (is_divu && !b_is_zero)  state_next = DIV;
      end
      MUL, DIV: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: sequential state is always updated with non-blocking assignments.
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: operand capture, iteration, output registers and done pulse.
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: iteration registers are reset too, so an aborted op leaves no residue.
    if (Reset) begin
      op_b     <= '0;
      acc      <= '0;
      lo       <= '0;
      cnt      <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (is_mulu || (is_divu && !b_is_zero)) begin
            op_b   <= is_mulu ? bus.A : bus.B;
            lo     <= is_mulu ? bus.B : bus.A;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else if (is_divu) begin
            result_q <= '1;
            hi_q     <= bus.A;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            result_q <= alu_res;
            hi_q     <= '0;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_ovf;
            dz_q     <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        MUL: begin
          acc <= mul_next[2*WIDTH-1:WIDTH];
          lo  <= mul_next[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (last) begin
            result_q <= mul_next[WIDTH-1:0];
            hi_q     <= mul_next[2*WIDTH-1:WIDTH];
            zero_q   <= (mul_next[WIDTH-1:0] == '0);
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DIV: begin
          acc <= div_rem;
          lo  <= div_quo;
          cnt <= cnt + 1'b1;
          if (last) begin
            result_q <= div_quo;
            hi_q     <= div_rem;
            zero_q   <= (div_quo == '0);
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.hi       = hi_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu: a 32-bit instance checked
// against an arithmetic reference model, plus an 8-bit instance for the
// narrow-width multiply/divide cases.
module tb_seq_alu;

  logic clk;
  logic rst;

  seq_alu_if #(.WIDTH(32)) bus ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(32), .CNT_W(6)) dut (.CLK(clk), .Reset(rst), .bus(bus));
  seq_alu #(.WIDTH(8),  .CNT_W(4)) dut8 (.CLK(clk), .Reset(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one operation at WIDTH=32, from plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] h,
                       output logic ov, output logic dz, output int lat);
    logic [63:0] p;
    r = 32'd0; h = 32'd0; ov = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = b << a[4:0];
      4'd7: r = b >> a[4:0];
      4'd8: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; h = p[63:32]; lat = 33; end
      4'd9: begin
        if (b == 32'd0) begin r = 32'hFFFF_FFFF; h = a; dz = 1'b1; end
        else begin r = a / b; h = a % b; lat = 33; end
      end
      default: r = 32'd0;
    endcase
  endtask

  // Issue one request in the current cycle (called at a negedge) and check
  // its completion; while busy, random requests are thrown at the DUT.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] er, eh;
    logic eov, edz;
    int elat, k, busy_cnt;
    bit got;
    model(op, a, b, er, eh, eov, edz, elat);
    bus.start = 1'b1; bus.ALUOp = op; bus.A = a; bus.B = b;
    k = 0; busy_cnt = 0; got = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.done) got = 1;
      else if (bus.busy) begin
        busy_cnt++;
        bus.start = 1'($urandom_range(0, 1));
        bus.ALUOp = 4'($urandom);
        bus.A = $urandom;
        bus.B = $urandom;
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (!got) begin
      check({tag, "/timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "/latency"}, 64'(k), 64'(elat));
    check({tag, "/busy_cycles"}, 64'(busy_cnt), (elat > 1) ? 64'd32 : 64'd0);
    check({tag, "/result"}, 64'(bus.result), 64'(er));
    check({tag, "/hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "/zero"}, 64'(bus.zero), 64'(er == 32'd0));
    check({tag, "/overflow"}, 64'(bus.overflow), 64'(eov));
    check({tag, "/div_zero"}, 64'(bus.div_zero), 64'(edz));
    last_res = er;
  endtask

  // One idle cycle: done must be low and the outputs must hold.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "/done_low"}, 64'(bus.done), 64'd0);
    check({tag, "/hold"}, 64'(bus.result), 64'(last_res));
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input string tag);
    logic [15:0] p;
    logic [7:0] er, eh;
    int k;
    bit got;
    p = {8'd0, a} * {8'd0, b};
    if (op == 4'd8) begin er = p[7:0]; eh = p[15:8]; end
    else begin er = a / b; eh = a % b; end
    bus8.start = 1'b1; bus8.ALUOp = op; bus8.A = a; bus8.B = b;
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      bus8.start = 1'b0;
      if (bus8.done) got = 1;
    end
    if (!got) begin
      check({tag, "/timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "/latency"}, 64'(k), 64'd9);
    check({tag, "/result"}, 64'(bus8.result), 64'(er));
    check({tag, "/hi"}, 64'(bus8.hi), 64'(eh));
  endtask

  initial begin
    int dones;
    logic [3:0] op;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.start = 1'b0; bus.ALUOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    bus8.start = 1'b0; bus8.ALUOp = 4'd0; bus8.A = 8'd0; bus8.B = 8'd0;
    last_res = 32'd0;
    repeat (2) @(negedge clk);

    check("reset/result", 64'(bus.result), 64'd0);
    check("reset/hi", 64'(bus.hi), 64'd0);
    check("reset/zero", 64'(bus.zero), 64'd1);
    check("reset/flags", {61'd0, bus.overflow, bus.div_zero, bus.busy}, 64'd0);
    check("reset/done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd0, 32'd10, 32'd20, "add");
    run_op(4'd1, 32'd9, 32'd6, "sub_b2b");
    idle_check("gap1");
    run_op(4'd1, 32'd5, 32'd5, "sub_zero");
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    run_op(4'd1, 32'h8000_0000, 32'd1, "sub_ovf");
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(4'd6, 32'd36, 32'h0000_0003, "sll");
    run_op(4'd7, 32'd31, 32'h8000_0000, "srl");
    run_op(4'd12, 32'd3, 32'd4, "op12");
    idle_check("gap2");
    run_op(4'd8, 32'hFFFF_FFFF, 32'd2, "mulu");
    idle_check("gap3");
    run_op(4'd9, 32'd100, 32'd7, "divu");
    run_op(4'd9, 32'd100, 32'd0, "divu_b0");
    idle_check("gap4");

    // Abort a multiply 10 cycles in with reset.
    bus.start = 1'b1; bus.ALUOp = 4'd8; bus.A = 32'hFFFF_FFFF; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/busy", 64'(bus.busy), 64'd0);
    check("abort/result", 64'(bus.result), 64'd0);
    check("abort/hi", 64'(bus.hi), 64'd0);
    check("abort/zero", 64'(bus.zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort/no_done", 64'(dones), 64'd0);
    last_res = 32'd0;
    run_op(4'd0, 32'd1, 32'd1, "add_after_reset");

    // Randomized operations, with directed corner operands mixed in.
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) idle_check("rand_gap");
      run_op(op, a, b, "rand");
    end

    // Narrow build.
    @(negedge clk);
    run8(4'd8, 8'hFF, 8'hFF, "w8_mulu_ff");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run8((i % 2 == 0) ? 4'd8 : 4'd9, 8'($urandom), 8'($urandom_range(1, 255)), "w8_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
